// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM controller: command codes, FSM states
// and request sources.
package spi_ram_pkg;

    localparam int CMD_W = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_e;

    typedef enum logic {
        SRC_SPI,
        SRC_HOST
    } src_e;

    // Only the data commands produce a RAM access; the address commands
    // merely update the address registers.
    function automatic logic isRequest(input cmd_e cmd);
        return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA);
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Bundles the SPI-slave, host and RAM-side signals of the controller.
// The slave modport is the controller's view; master is the environment's.
interface spi_ram_ctrl_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    logic [CMD_W-1:0]  rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              spi_overrun;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output tx_data, tx_valid, spi_overrun, host_gnt, host_rvalid, host_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  tx_data, tx_valid, spi_overrun, host_gnt, host_rvalid, host_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/spi_cmd_capture.sv
// Decodes SPI command words on the rising edge of rx_valid, keeps the
// write/read address registers and the single pending-request slot.
module spi_cmd_capture
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  i_rxData,
    input  logic              i_rxValid,
    input  logic              i_take,
    output logic              o_slotValid,
    output logic              o_slotWe,
    output logic [ADDR_W-1:0] o_slotAddr,
    output logic [DATA_W-1:0] o_slotData,
    output logic              o_overrun
);

    logic              r_rxPrev;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [ADDR_W-1:0] r_rdAddr;
    logic              r_slotValid;
    logic              r_slotWe;
    logic [ADDR_W-1:0] r_slotAddr;
    logic [DATA_W-1:0] r_slotData;
    logic              r_overrun;

    logic              w_edge;
    logic              w_isReq;
    cmd_e              w_cmd;
    logic [7:0]        w_payload;

    assign w_edge    = i_rxValid & ~r_rxPrev;
    assign w_cmd     = cmd_e'(i_rxData[9:8]);
    assign w_payload = i_rxData[7:0];
    assign w_isReq   = w_edge & isRequest(w_cmd);

    // A new request landing while the slot is still waiting replaces it; if
    // the old one is being taken this very cycle it is simply a refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxPrev    <= 1'b0;
            r_wrAddr    <= '0;
            r_rdAddr    <= '0;
            r_slotValid <= 1'b0;
            r_slotWe    <= 1'b0;
            r_slotAddr  <= '0;
            r_slotData  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_rxPrev  <= i_rxValid;
            r_overrun <= w_isReq & r_slotValid & ~i_take;
            if (w_edge && (w_cmd == CMD_WR_ADDR)) begin
                r_wrAddr <= ADDR_W'(w_payload);
            end
            if (w_edge && (w_cmd == CMD_RD_ADDR)) begin
                r_rdAddr <= ADDR_W'(w_payload);
            end
            if (w_isReq) begin
                r_slotValid <= 1'b1;
                r_slotWe    <= (w_cmd == CMD_WR_DATA);
                r_slotAddr  <= (w_cmd == CMD_WR_DATA) ? r_wrAddr : r_rdAddr;
                r_slotData  <= DATA_W'(w_payload);
            end else if (i_take) begin
                r_slotValid <= 1'b0;
            end
        end
    end

    assign o_slotValid = r_slotValid;
    assign o_slotWe    = r_slotWe;
    assign o_slotAddr  = r_slotAddr;
    assign o_slotData  = r_slotData;
    assign o_overrun   = r_overrun;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Arbitrates one single-port RAM between SPI commands and a host port,
// returning read data to the SPI slave (held) or the host (pulsed).
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TX_HOLD = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_ram_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(TX_HOLD + 1);

    state_e            r_state;
    state_e            w_nextState;
    src_e              r_src;
    src_e              r_lastGrant;
    src_e              w_winner;
    logic              w_select;
    logic              w_take;

    logic              w_slotValid;
    logic              w_slotWe;
    logic [ADDR_W-1:0] w_slotAddr;
    logic [DATA_W-1:0] w_slotData;
    logic              w_overrun;

    logic              r_ramEn;
    logic              r_ramWe;
    logic [ADDR_W-1:0] r_ramAddr;
    logic [DATA_W-1:0] r_ramWdata;
    logic              r_hostGnt;
    logic              r_hostRvalid;
    logic [DATA_W-1:0] r_hostRdata;
    logic [DATA_W-1:0] r_txData;
    logic              r_txValid;
    logic [CNT_W-1:0]  r_txCnt;

    spi_cmd_capture #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rxData    (bus.rx_data),
        .i_rxValid   (bus.rx_valid),
        .i_take      (w_take),
        .o_slotValid (w_slotValid),
        .o_slotWe    (w_slotWe),
        .o_slotAddr  (w_slotAddr),
        .o_slotData  (w_slotData),
        .o_overrun   (w_overrun)
    );

    assign w_take = w_select & (w_winner == SRC_SPI);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // On a tie the source that did not win last time goes first.
    always_comb begin
        w_nextState = r_state;
        w_select    = 1'b0;
        w_winner    = SRC_SPI;
        case (r_state)
            IDLE: begin
                if (w_slotValid || bus.host_req) begin
                    w_select    = 1'b1;
                    w_nextState = ACCESS;
                    if (w_slotValid && bus.host_req) begin
                        w_winner = (r_lastGrant == SRC_HOST) ? SRC_SPI : SRC_HOST;
                    end else begin
                        w_winner = w_slotValid ? SRC_SPI : SRC_HOST;
                    end
                end
            end
            ACCESS:  w_nextState = r_ramWe ? IDLE : RDATA;
            RDATA:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A fresh SPI read result overrides whatever tx_data is still showing
    // and restarts the hold window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src        <= SRC_SPI;
            r_lastGrant  <= SRC_HOST;
            r_ramEn      <= 1'b0;
            r_ramWe      <= 1'b0;
            r_ramAddr    <= '0;
            r_ramWdata   <= '0;
            r_hostGnt    <= 1'b0;
            r_hostRvalid <= 1'b0;
            r_hostRdata  <= '0;
            r_txData     <= '0;
            r_txValid    <= 1'b0;
            r_txCnt      <= '0;
        end else begin
            r_ramEn      <= 1'b0;
            r_hostGnt    <= 1'b0;
            r_hostRvalid <= 1'b0;
            if (w_select) begin
                r_ramEn     <= 1'b1;
                r_src       <= w_winner;
                r_lastGrant <= w_winner;
                r_hostGnt   <= (w_winner == SRC_HOST);
                if (w_winner == SRC_SPI) begin
                    r_ramWe    <= w_slotWe;
                    r_ramAddr  <= w_slotAddr;
                    r_ramWdata <= w_slotData;
                end else begin
                    r_ramWe    <= bus.host_we;
                    r_ramAddr  <= bus.host_addr;
                    r_ramWdata <= bus.host_wdata;
                end
            end
            if ((r_state == RDATA) && (r_src == SRC_HOST)) begin
                r_hostRdata  <= bus.ram_rdata;
                r_hostRvalid <= 1'b1;
            end
            if ((r_state == RDATA) && (r_src == SRC_SPI)) begin
                r_txData  <= bus.ram_rdata;
                r_txValid <= 1'b1;
                r_txCnt   <= CNT_W'(TX_HOLD - 1);
            end else if (r_txValid) begin
                if (r_txCnt == '0) begin
                    r_txValid <= 1'b0;
                end else begin
                    r_txCnt <= r_txCnt - 1'b1;
                end
            end
        end
    end

    assign bus.ram_en      = r_ramEn;
    assign bus.ram_we      = r_ramWe;
    assign bus.ram_addr    = r_ramAddr;
    assign bus.ram_wdata   = r_ramWdata;
    assign bus.host_gnt    = r_hostGnt;
    assign bus.host_rvalid = r_hostRvalid;
    assign bus.host_rdata  = r_hostRdata;
    assign bus.tx_data     = r_txData;
    assign bus.tx_valid    = r_txValid;
    assign bus.spi_overrun = w_overrun;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: a behavioural RAM, a vector table of SPI
// write/read pairs, directed corner sequences and a randomized two-source run.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    localparam int TX_HOLD = 9;

    logic clk;
    logic rst_n;
    logic ramFill;
    logic [7:0] ramRdata;
    logic [7:0] mem [256];
    logic [7:0] refMem [256];
    int tests = 0;
    int fails = 0;
    int ovTotal = 0;

    typedef struct {
        logic [9:0] cmdA;
        logic [9:0] cmdB;
        logic       expWe;
        logic [7:0] expAddr;
        logic [7:0] expWdata;
        logic [7:0] expTx;
    } vec_t;

    vec_t vecs [8];

    spi_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .TX_HOLD(TX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after ram_en.
    assign bus.ram_rdata = ramRdata;
    always @(posedge clk) begin
        if (ramFill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else ramRdata <= mem[bus.ram_addr];
        end
    end

    always @(negedge clk) if (bus.spi_overrun === 1'b1) ovTotal++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] allOuts();
        return 64'({bus.tx_data, bus.tx_valid, bus.spi_overrun, bus.host_gnt, bus.host_rvalid,
                    bus.host_rdata, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raises rx_valid with a new word and returns at the negedge of that cycle.
    task automatic applyStimulus(input logic [9:0] word);
        @(posedge clk); #1;
        bus.rx_data  = word;
        bus.rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic dropRx();
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    // Checks a complete tx_valid window starting at the current negedge.
    task automatic checkTxWindow(input string name, input logic [7:0] expData);
        int cnt;
        checkOutput({name, "TxValid"}, bus.tx_valid, 1'b1);
        checkOutput({name, "TxData"}, bus.tx_data, expData);
        cnt = 0;
        while (bus.tx_valid === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput({name, "TxHold"}, cnt, TX_HOLD);
    endtask

    task automatic waitTx(input string name, input logic [7:0] expData);
        int guard;
        guard = 0;
        while (bus.tx_valid !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (bus.tx_valid !== 1'b1) checkOutput({name, "TxTimeout"}, 1, 0);
        else checkTxWindow(name, expData);
    endtask

    task automatic hostProc();
        logic [7:0] a, d;
        logic       we;
        int         guard;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            we = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(128, 255));
            d  = 8'($urandom);
            @(posedge clk); #1;
            bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (bus.host_gnt !== 1'b1 && guard < 30);
            if (bus.host_gnt !== 1'b1) begin
                checkOutput("hostGntTimeout", 1, 0);
                @(posedge clk); #1 bus.host_req = 1'b0;
                continue;
            end
            if (we) refMem[a] = d;
            @(posedge clk); #1 bus.host_req = 1'b0;
            if (!we) begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (bus.host_rvalid !== 1'b1 && guard < 10);
                if (bus.host_rvalid !== 1'b1) checkOutput("hostRvalidTimeout", 1, 0);
                else checkOutput("hostRandRead", bus.host_rdata, refMem[a]);
            end
        end
    endtask

    task automatic spiProc();
        logic [7:0] a, d;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = 8'($urandom_range(0, 127));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus({2'b00, a}); dropRx();
                applyStimulus({2'b01, d}); dropRx();
                refMem[a] = d;
            end else begin
                applyStimulus({2'b10, a}); dropRx();
                applyStimulus({2'b11, d}); dropRx();
                waitTx("spiRand", refMem[a]);
            end
        end
        repeat (8) @(posedge clk);
    endtask

    logic grantQ [$];
    logic [7:0] spiWrQ [$];
    int guard, ovBase, cnt, bad;
    logic [3:0] expGrant;

    initial begin
        vecs[0] = '{10'h03C, 10'h1A5, 1'b1, 8'h3C, 8'hA5, 8'h00};
        vecs[1] = '{10'h23C, 10'h300, 1'b0, 8'h3C, 8'h00, 8'hA5};
        vecs[2] = '{10'h0FF, 10'h100, 1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{10'h2FF, 10'h3AA, 1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[4] = '{10'h000, 10'h1FF, 1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{10'h200, 10'h355, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[6] = '{10'h080, 10'h17E, 1'b1, 8'h80, 8'h7E, 8'h00};
        vecs[7] = '{10'h280, 10'h3C3, 1'b0, 8'h80, 8'h00, 8'h7E};

        rst_n = 1'b0; ramFill = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_data = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        repeat (3) @(posedge clk);
        #1 ramFill = 1'b0;
        @(negedge clk);
        checkOutput("resetOutputs", allOuts(), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Contention right after reset: SPI wins the first tie, then alternation.
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            case (k)
                0: begin bus.rx_data = 10'h155; bus.rx_valid = 1'b1; end
                1: begin bus.rx_valid = 1'b0; bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h20; end
                2: begin bus.rx_data = 10'h166; bus.rx_valid = 1'b1; end
                3: bus.rx_valid = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (bus.ram_en === 1'b1) grantQ.push_back(bus.host_gnt);
        end
        @(posedge clk); #1 bus.host_req = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("contGrantCount", grantQ.size() >= 4, 1'b1);
        expGrant = 4'b1010;
        for (int i = 0; i < 4 && i < grantQ.size(); i++)
            checkOutput($sformatf("contGrant%0d", i), grantQ[i], expGrant[i]);
        checkOutput("contMem0", mem[0], 8'h66);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cmdA); dropRx();
            applyStimulus(vecs[i].cmdB);
            checkOutput($sformatf("vec%0dRamEnN", i), bus.ram_en, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0dRamEnN1", i), bus.ram_en, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0dRamEn", i), bus.ram_en, 1'b1);
            checkOutput($sformatf("vec%0dRamWe", i), bus.ram_we, vecs[i].expWe);
            checkOutput($sformatf("vec%0dRamAddr", i), bus.ram_addr, vecs[i].expAddr);
            if (vecs[i].expWe) begin
                checkOutput($sformatf("vec%0dRamWdata", i), bus.ram_wdata, vecs[i].expWdata);
            end else begin
                @(negedge clk);
                checkOutput($sformatf("vec%0dTxEarly", i), bus.tx_valid, 1'b0);
                @(negedge clk);
                checkTxWindow($sformatf("vec%0d", i), vecs[i].expTx);
            end
            dropRx();
            repeat (2) @(posedge clk);
        end
        checkOutput("tableOverrun", ovTotal, 0);

        // Host write then back-to-back read of the same word.
        @(posedge clk); #1;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h10; bus.host_wdata = 8'h77;
        guard = 0;
        do begin @(negedge clk); guard++; end while (bus.host_gnt !== 1'b1 && guard < 20);
        checkOutput("hostWrGnt", bus.host_gnt, 1'b1);
        @(posedge clk); #1 bus.host_we = 1'b0;
        @(negedge clk);
        checkOutput("hostRdGntEarly", bus.host_gnt, 1'b0);
        @(negedge clk);
        checkOutput("hostRdGnt", {bus.host_gnt, bus.ram_en, bus.ram_we, bus.ram_addr}, {1'b1, 1'b1, 1'b0, 8'h10});
        @(posedge clk); #1 bus.host_req = 1'b0;
        @(negedge clk);
        checkOutput("hostRvalidEarly", bus.host_rvalid, 1'b0);
        @(negedge clk);
        checkOutput("hostRvalid", {bus.host_rvalid, bus.host_rdata}, {1'b1, 8'h77});
        @(negedge clk);
        checkOutput("hostRvalidPulse", bus.host_rvalid, 1'b0);

        // Two SPI writes arrive while the host keeps the RAM busy.
        ovBase = ovTotal;
        applyStimulus(10'h040); dropRx();
        @(posedge clk); #1;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h30;
        guard = 0;
        do begin @(negedge clk); guard++; end while (bus.host_gnt !== 1'b1 && guard < 20);
        checkOutput("ovrHostGnt", bus.host_gnt, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            case (k)
                1: begin bus.rx_data = 10'h111; bus.rx_valid = 1'b1; end
                2: bus.rx_valid = 1'b0;
                3: begin bus.rx_data = 10'h122; bus.rx_valid = 1'b1; end
                4: bus.rx_valid = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) spiWrQ.push_back(bus.ram_wdata);
        end
        @(posedge clk); #1 bus.host_req = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("ovrPulses", ovTotal - ovBase, 1);
        checkOutput("ovrWriteCount", spiWrQ.size(), 1);
        if (spiWrQ.size() > 0) checkOutput("ovrWriteData", spiWrQ[0], 8'h22);
        checkOutput("ovrMem", mem[8'h40], 8'h22);

        // Reset while an SPI read sits in RDATA.
        applyStimulus(10'h23C); dropRx();
        applyStimulus(10'h300);
        dropRx();
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstMidOutputs", allOuts(), 64'h0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b0 || bus.host_rvalid !== 1'b0) cnt++;
        end
        checkOutput("rstNoResponse", cnt, 0);
        applyStimulus(10'h23C); dropRx();
        applyStimulus(10'h300);
        repeat (3) @(negedge clk);
        checkOutput("rstReadTxEarly", bus.tx_valid, 1'b0);
        @(negedge clk);
        checkTxWindow("rstRead", 8'hA5);
        dropRx();
        repeat (3) @(posedge clk);

        // Randomized: host on the upper half, SPI on the lower half.
        ovBase = ovTotal;
        for (int i = 0; i < 256; i++) refMem[i] = mem[i];
        fork
            hostProc();
            spiProc();
        join
        repeat (6) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) bad++;
        checkOutput("randMemImage", bad, 0);
        checkOutput("randOverrun", ovTotal - ovBase, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Controller that sits between the SPI slave and the single-port RAM, and between that RAM and a local host port. It decodes the 10-bit command words the SPI slave delivers and turns them into RAM accesses. It returns read data to the slave on tx_data/tx_valid. It arbitrates the single RAM port between SPI and host requests with alternating priority.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- TX_HOLD, 9, cycles tx_valid stays high per SPI read
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rx_data  in  10  SPI command word: [9:8] cmd, [7:0] payload
- rx_valid  in  1  from SPI slave; level, may stay high many cycles
- tx_data  out  DATA_W  read data to SPI slave
- tx_valid  out  1  tx_data valid, held TX_HOLD cycles
- spi_overrun  out  1  1-cycle pulse: pending SPI access overwritten
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  1-cycle pulse: host request accepted
- host_rvalid  out  1  1-cycle pulse: host_rdata valid
- host_rdata  out  DATA_W  host read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en

## Operation
- **Command capture.** A command is accepted on the rising edge of rx_valid: rx_valid=1 this cycle, 0 the previous cycle (prev register resets to 0). rx_data is sampled in that cycle.
- **Command codes.**
  - 00: wr_addr ← payload.
  - 01: write request; address = wr_addr, data = payload.
  - 10: rd_addr ← payload.
  - 11: read request; address = rd_addr; payload ignored.
- **SPI pending slot.** Single slot holding {we, addr, data}, snapshotted at capture. A later address command does not alter a request already in the slot.
- **Overrun.** A new 01/11 command while the slot is pending and not selected this cycle replaces the slot contents and pulses spi_overrun.
- **Host handshake.** The host holds req, we, addr and wdata stable until it samples host_gnt=1. The next cycle it may drop req or present a new request.
- **FSM states.**
  - IDLE: if any request is present, select a winner, register ram_we, ram_addr and ram_wdata, and go to ACCESS.
  - ACCESS: ram_en=1 for one cycle; host_gnt=1 if the host won. A write returns to IDLE; a read goes to RDATA.
  - RDATA: capture ram_rdata. For SPI: tx_data ← ram_rdata, tx_valid=1 from the next cycle for TX_HOLD cycles. For host: host_rdata ← ram_rdata, host_rvalid pulses next cycle. Return to IDLE.
- **Arbitration.** If only one source requests, it wins. If both request, the source not granted last wins. last_grant resets to HOST, so SPI wins the first tie. The SPI slot clears when SPI is selected.
- **Simultaneous events.**
  - rx_valid edge in the same cycle SPI is selected: the old slot is served, the new command loads the slot, no overrun.
  - New SPI read completing while tx_valid is still high: tx_data is replaced and the hold counter restarts.
- **Reset mid-operation.** The FSM returns to IDLE and the slot and address registers clear. An in-flight read is discarded: no tx_valid and no host_rvalid.

## Timing
- **Reset values.** All outputs 0: tx_data, tx_valid, spi_overrun, host_gnt, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata. The wr_addr/rd_addr registers also clear to 0. FSM in IDLE.
- **SPI latency.** Let N be the cycle of the rx_valid rising edge, no contention:
  - slot valid at N+1;
  - ram_en at N+2;
  - tx_valid first high at N+4, low again at N+4+TX_HOLD.
- **Host latency.** Let M be the cycle host_req is sampled in IDLE:
  - host_gnt and ram_en at M+1;
  - host_rvalid at M+3 for a read.
- **Throughput.** One write per 2 cycles, one read per 3 cycles. Under contention, worst-case SPI wait is one host access.
- All outputs are registered; no combinational input→output paths.

## Structure
- **Package spi_ram_pkg:**
  - cmd_e {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11};
  - state_e {IDLE, ACCESS, RDATA};
  - src_e {SRC_SPI, SRC_HOST}.
- **Sub-module spi_cmd_capture:** rx_valid edge detect, address registers, pending slot and overrun. The top level holds the FSM, arbiter and response registers.

## Test plan
- **SPI write.** rx_data=0x03C rising edge, then 0x1A5 rising edge at cycle N → cycle N+2: ram_en=1, ram_we=1, ram_addr=0x3C, ram_wdata=0xA5.
- **SPI read.** 0x23C, then 0x300 at cycle N; RAM returns 0xA5 → ram_en at N+2 with addr 0x3C, we=0; tx_data=0xA5 with tx_valid high exactly 9 cycles from N+4.
- **Host read.** host_req=1, we=0, addr=0x10; RAM holds 0x77 → host_gnt 1 cycle later; host_rvalid=1 with host_rdata=0x77 two cycles after gnt.
- **Contention.** host_req held continuously, SPI write 0x155 (wr_addr=0) pending → SPI granted first after reset; then host and SPI accesses alternate.
- **Overrun.** Host occupies the RAM with back-to-back reads; two SPI write commands 0x111 then 0x122 arrive before SPI is selected → spi_overrun pulses once; only data 0x22 is written.
- **Reset during RDATA.** Assert rst_n=0 for 1 cycle while a SPI read is in RDATA → no tx_valid; all outputs 0 the next cycle; the next SPI read works normally.
